// File: rtl/block_map_writer.sv
// block_map_writer: fills the 33x26 block-map RAM after reset/regen, then serves single-block clear requests.
// Define BLOCK_MAP_RANDOM_EN for the LFSR/DENSITY fill; otherwise every eligible cell gets a block.
module block_map_writer #(
    parameter int          DENSITY   = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regen,
    input  logic        clr_req,
    input  logic [5:0]  clr_col,
    input  logic [4:0]  clr_row,
    output logic        clr_ack,
    output logic        clr_hit,
    output logic        we,
    output logic [10:0] waddr,
    output logic        wdata,
    output logic        ready
);
    localparam logic [1:0] INIT  = 2'd0;
    localparam logic [1:0] READY = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic        we_q, we_d;
    logic [10:0] waddr_q, waddr_d;
    logic        wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        ack_q, ack_d;
    logic        hit_q, hit_d;
    logic        eligible, fill, clr_valid, last_col, last_cell;

    assign last_col  = col_q == 6'd32;
    assign last_cell = last_col && row_q == 5'd25;
    assign eligible  = !(col_q[0] && row_q[0]) && !(row_q == 5'd0 && col_q <= 6'd1)
                       && !(col_q == 6'd0 && row_q == 5'd1);
    assign clr_valid = clr_col <= 6'd32 && clr_row <= 5'd25 && !(clr_col[0] && clr_row[0]);

`ifdef BLOCK_MAP_RANDOM_EN
    logic [15:0] lfsr_q;

    assign fill = eligible && ({1'b0, lfsr_q[2:0]} < 4'(DENSITY));

    // Advances on every swept cell, so the pattern depends only on the seed.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            lfsr_q <= LFSR_SEED;
        else if (regen)
            lfsr_q <= LFSR_SEED;
        else if (state_q == INIT)
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`else
    assign fill = eligible;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = 1'b0;
        waddr_d = 11'd0;
        wdata_d = 1'b0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        hit_d   = 1'b0;
        if (regen) begin
            state_d = INIT;
            col_d   = 6'd0;
            row_d   = 5'd0;
        end else begin
            case (state_q)
                INIT: begin
                    we_d    = 1'b1;
                    waddr_d = {row_q, col_q};
                    wdata_d = fill;
                    col_d   = last_col ? 6'd0 : col_q + 6'd1;
                    row_d   = last_cell ? 5'd0 : (last_col ? row_q + 5'd1 : row_q);
                    state_d = last_cell ? READY : INIT;
                end
                READY: begin
                    // ready_q gates acceptance so the cycle right after the sweep ignores requests.
                    if (clr_req && ready_q) begin
                        state_d = WRITE;
                        we_d    = clr_valid;
                        waddr_d = {clr_row, clr_col};
                        ack_d   = 1'b1;
                        hit_d   = clr_valid;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                WRITE: begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= INIT;
            col_q   <= 6'd0;
            row_q   <= 5'd0;
            we_q    <= 1'b0;
            waddr_q <= 11'd0;
            wdata_q <= 1'b0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            hit_q   <= hit_d;
        end

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign ready   = ready_q;
    assign clr_ack = ack_q;
    assign clr_hit = hit_q;
endmodule

// File: doc/block_map_writer.md
BLOCK_MAP_WRITER -- requirements
Module: block_map_writer

Interface
REQ-001 SHALL have parameter DENSITY, default 5, meaning the fill threshold (0-8): an eligible cell gets a block when lfsr[2:0] < DENSITY.
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR value loaded at reset and on regen.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port regen, input, 1 bit: restart the map fill (new round).
REQ-006 SHALL have ports clr_req (input, 1 bit), clr_col (input, 6 bits) and clr_row (input, 5 bits): request to clear one destroyed block.
REQ-007 SHALL have ports clr_ack (output, 1 bit) and clr_hit (output, 1 bit): request completed, and whether a write was performed.
REQ-008 SHALL have ports we (output, 1 bit), waddr (output, 11 bits) and wdata (output, 1 bit): block-map RAM write port, waddr = {row[4:0], col[5:0]}.
REQ-009 SHALL have port ready, output, 1 bit: map valid, clear requests accepted.

Function
REQ-010 Grid SHALL be 33 columns (0-32) by 26 rows (0-25), 16x16-px tiles, play-area origin at pixel (48,32).
REQ-011 Pillar cell SHALL be defined as col odd AND row odd; protected cells SHALL be (0,0), (1,0) and (0,1) (player spawn).
REQ-012 FSM states SHALL be INIT, READY and WRITE.
REQ-013 INIT SHALL sweep one cell per cycle, col fastest, row-major order, asserting we=1 every cycle.
REQ-014 In INIT, wdata SHALL be 1 only for a non-pillar, non-protected cell that passes the fill rule; otherwise 0, so stale blocks are erased.
REQ-015 The 16-bit Galois LFSR (mask 16'hB400) SHALL advance once per INIT cell, including pillar and protected cells.
REQ-016 Write-port outputs SHALL be registered.
REQ-017 The first INIT write, cell (0,0), SHALL appear at the first rising edge after reset release; the last, (25,32), at edge 858.
REQ-018 ready SHALL rise at edge 859, with FSM in READY.
REQ-019 In READY with clr_req=1, the FSM SHALL go to WRITE on the next edge and ready SHALL drop for that one cycle.
REQ-020 In WRITE for a valid non-pillar cell: we=1, waddr={clr_row,clr_col} as captured, wdata=0, clr_ack=1, clr_hit=1, for exactly one cycle; then back to READY.
REQ-021 In WRITE for a pillar cell, col>32 or row>25: we=0, clr_ack=1, clr_hit=0 for one cycle.
REQ-022 clr_col/clr_row SHALL be captured on the accepting edge; later changes SHALL be ignored.
REQ-023 clr_req SHALL be ignored whenever ready=0; no ack and no queueing.
REQ-024 regen=1 in any state SHALL go to INIT at the next edge: counters to 0, LFSR to LFSR_SEED, ready=0, any pending WRITE aborted without ack.
REQ-025 regen SHALL take priority over a simultaneous clr_req.

Reset
REQ-026 On reset low, immediately: state=INIT, col/row counters=0, lfsr=LFSR_SEED, we=0, waddr=0, wdata=0, ready=0, clr_ack=0, clr_hit=0.
REQ-027 Reset asserted mid-INIT or mid-WRITE SHALL abort the operation; the sweep restarts from (0,0) after release.

Configuration
REQ-028 Macro BLOCK_MAP_RANDOM_EN SHALL control the fill rule.
REQ-029 With BLOCK_MAP_RANDOM_EN defined, the LFSR and DENSITY fill rule SHALL apply.
REQ-030 Without BLOCK_MAP_RANDOM_EN, the LFSR SHALL be absent and every non-pillar, non-protected cell SHALL get wdata=1; DENSITY and LFSR_SEED SHALL be unused.

Verification
REQ-031 Reset release, macro undefined: expect 858 writes; count of wdata=1 is 647; (0,0)->0, (1,1)->0, (2,0)->1; ready=1 at edge 859.
REQ-032 READY, clr_req with col=4 row=2 for one cycle: next cycle we=1, waddr=11'h084, wdata=0, clr_ack=1, clr_hit=1; ready low that cycle only.
REQ-033 READY, clr_req with col=3 row=5 (pillar), then col=40 row=0: each gives clr_ack=1, clr_hit=0, we=0.
REQ-034 Reset pulsed low at sweep cell 400: outputs zero immediately; after release the sweep restarts at (0,0) and ready rises 859 edges later.
REQ-035 regen and clr_req in the same READY cycle: no clr_ack; INIT restarts at (0,0); macro defined: the bit sequence is identical to the post-reset sweep.
REQ-036 Macro defined, DENSITY=0: all 858 writes have wdata=0; DENSITY=8: 647 ones.
